// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N-to-1 valid/ready stream mux feeding one registered output stage.
// Define STREAM_MUX_RR_ARB_EN to add round-robin arbitration selected at run time by auto_en.
module stream_mux_nto1 #(
  parameter int N_IN  = 3,
  parameter int WIDTH = 32,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  auto_en,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1 on the
  // same side; valid never waits for ready, and a presented out beat holds until taken.

  localparam logic [SEL_W:0] N_IN_W = (SEL_W+1)'(N_IN);

  logic             can_load;
  logic             sel_ok;
  logic             grant_vld;
  logic [SEL_W-1:0] g;
  logic             sel_err_nxt;
  logic             xfer;

  assign can_load = !out_valid || out_ready;
  assign sel_ok   = ({1'b0, sel} < N_IN_W);

`ifdef STREAM_MUX_RR_ARB_EN
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_g;
  logic [SEL_W-1:0] rr_cand;
  logic             rr_found;
  int               rr_idx;

  // First requesting channel at or after ptr, wrapping modulo N_IN.
  always_comb begin
    rr_found = 1'b0;
    rr_g     = '0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int k = 0; k < N_IN; k++) begin
      rr_idx  = (int'(ptr) + k) % N_IN;
      rr_cand = SEL_W'(rr_idx);
      if (!rr_found && in_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_g     = rr_cand;
      end
    end
  end

  assign g           = auto_en ? rr_g : sel;
  assign grant_vld   = auto_en ? rr_found : sel_ok;
  assign sel_err_nxt = !auto_en && !sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (auto_en && xfer) begin
      ptr <= (rr_g == SEL_W'(N_IN - 1)) ? '0 : rr_g + 1'b1;
    end
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;

  assign g           = sel;
  assign grant_vld   = sel_ok;
  assign sel_err_nxt = !sel_ok;
`endif

  always_comb begin
    in_ready = '0;
    if (rst_n && can_load && grant_vld) in_ready[g] = 1'b1;
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= sel_err_nxt;
      if (xfer) begin
        out_data  <= in_data[g*WIDTH +: WIDTH];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1: directed vectors, expected beats queued at issue
// and popped by a monitor whenever the output handshake completes.
module tb_stream_mux_nto1;

  localparam int N_IN  = 3;
  localparam int WIDTH = 32;

  logic                  clk;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [1:0]            sel;
  logic                  auto_en;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  stream_mux_nto1 #(.N_IN(N_IN), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .auto_en   (auto_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected act=%h exp=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL beat_data act=%h exp=%h", out_data, e);
        end
      end
    end
  end

  initial begin
    logic [2:0] oh;
    int seq5[4];
    int seq5b[2];
    rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; auto_en = 1'b0; out_ready = 1'b0;

    // reset state
    cyc();
    in_valid = 3'b111; sel = 2'd0; out_ready = 1'b1; #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    rst_n = 1'b1; in_valid = '0;
    cyc();

    // T2 manual select, back-to-back
    set_ch(0, 32'h1111_0000); set_ch(1, 32'h2222_0000); set_ch(2, 32'hDEAD_BEEF);
    sel = 2'd2; in_valid = 3'b111; out_ready = 1'b1; #1;
    chk("t2_in_ready", 32'(in_ready), 32'h4);
    exp_q.push_back(32'hDEAD_BEEF);
    cyc();
    chk("t2_out_valid", 32'(out_valid), 32'h1);
    chk("t2_out_data", out_data, 32'hDEAD_BEEF);
    set_ch(2, 32'h0BAD_F00D); #1;
    chk("t2_b2b_ready", 32'(in_ready), 32'h4);
    exp_q.push_back(32'h0BAD_F00D);
    cyc();
    chk("t2_b2b_data", out_data, 32'h0BAD_F00D);
    set_ch(2, 32'hCAFE_0003);
    exp_q.push_back(32'hCAFE_0003);
    cyc();

    // T3 stall
    sel = 2'd0; set_ch(0, 32'h1); in_valid = 3'b001;
    exp_q.push_back(32'h1);
    cyc();
    out_ready = 1'b0; in_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i % 2);
      set_ch(0, 32'h100 + 32'(i)); set_ch(1, 32'h200 + 32'(i)); #1;
      chk("t3_stall_data", out_data, 32'h1);
      chk("t3_stall_valid", 32'(out_valid), 32'h1);
      chk("t3_stall_ready", 32'(in_ready), 32'h0);
      cyc();
    end
    out_ready = 1'b1; sel = 2'd0; set_ch(0, 32'h5); in_valid = 3'b001; #1;
    chk("t3_release_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(32'h5);
    cyc();
    chk("t3_release_data", out_data, 32'h5);

    // T4 out-of-range select
    sel = 2'b11; in_valid = 3'b111; #1;
    chk("t4_in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("t4_sel_err", 32'(sel_err), 32'h1);
    chk("t4_drained", 32'(out_valid), 32'h0);
    sel = 2'd1; set_ch(1, 32'h77); #1;
    chk("t4_recover_ready", 32'(in_ready), 32'h2);
    exp_q.push_back(32'h77);
    cyc();
    chk("t4_sel_err_clear", 32'(sel_err), 32'h0);
    chk("t4_recover_data", out_data, 32'h77);
    in_valid = '0;
    cyc();

    // T1 async reset mid-stall
    sel = 2'd0; set_ch(0, 32'hABCD); in_valid = 3'b001;
    exp_q.push_back(32'hABCD);
    cyc();
    out_ready = 1'b0; in_valid = 3'b111; sel = 2'b11;
    cyc();
    chk("t1_pre_valid", 32'(out_valid), 32'h1);
    chk("t1_pre_sel_err", 32'(sel_err), 32'h1);
    out_ready = 1'b1; sel = 2'd0; rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'h0);
    chk("t1_out_data", out_data, 32'h0);
    chk("t1_sel_err", 32'(sel_err), 32'h0);
    chk("t1_in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("t1_in_ready_hold", 32'(in_ready), 32'h0);
    rst_n = 1'b1; in_valid = '0;
    cyc();
    sel = 2'd1; set_ch(1, 32'h5151); in_valid = 3'b010;
    exp_q.push_back(32'h5151);
    cyc();
    chk("t1_after_data", out_data, 32'h5151);
    in_valid = '0;
    cyc();

`ifdef STREAM_MUX_RR_ARB_EN
    // T5 round robin
    auto_en = 1'b1; sel = 2'b11; out_ready = 1'b1; in_valid = 3'b111;
    set_ch(0, 32'hA0); set_ch(1, 32'hA1); set_ch(2, 32'hA2);
    seq5 = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      #1;
      oh = 3'b001 << seq5[i];
      chk("t5_rr_ready", 32'(in_ready), 32'(oh));
      exp_q.push_back(32'hA0 + 32'(seq5[i]));
      cyc();
      chk("t5_sel_err", 32'(sel_err), 32'h0);
    end
    in_valid = 3'b101;
    seq5b = '{2, 0};
    for (int i = 0; i < 2; i++) begin
      #1;
      oh = 3'b001 << seq5b[i];
      chk("t5_rr_skip_ready", 32'(in_ready), 32'(oh));
      exp_q.push_back(32'hA0 + 32'(seq5b[i]));
      cyc();
    end

    // T6 round robin stall
    out_ready = 1'b0; in_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_stall_ready", 32'(in_ready), 32'h0);
      cyc();
      chk("t6_hold_data", out_data, 32'hA0);
    end
    out_ready = 1'b1; #1;
    chk("t6_resume_ready", 32'(in_ready), 32'h2);
    exp_q.push_back(32'hA1);
    cyc();
    chk("t6_resume_data", out_data, 32'hA1);
    in_valid = '0; auto_en = 1'b0;
    cyc();
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
